// File: rtl/corr_pkg.sv
// Shared definitions for the correlator scanner: FSM states, address map
// constants and result width.
package corr_pkg;

  localparam int          CORR_NCH            = 8;
  localparam logic [7:0]  CORR_RESTART_ADDR   = 8'hFF;
  localparam int          CORR_CAPTURE_CYCLES = 2048;
  localparam int          CORR_RES_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTART,
    ST_INTEG,
    ST_ADDR,
    ST_WAIT,
    ST_LATCH,
    ST_DONE
  } corr_state_t;

endpackage

// File: rtl/corr_max_tracker.sv
// Running maximum (and, with CORR_SCAN_MARGIN_EN, runner-up) over a stream of
// indexed results. The first value after clear seeds the maximum directly.
module corr_max_tracker
  import corr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [CORR_RES_W-1:0] value,
  input  logic [2:0]            index,
  output logic [CORR_RES_W-1:0] max_val,
  output logic [2:0]            max_idx
`ifdef CORR_SCAN_MARGIN_EN
  ,
  output logic [CORR_RES_W-1:0] second_val
`endif
);

  logic first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first   <= 1'b1;
      max_val <= '0;
      max_idx <= '0;
    end else if (clear) begin
      first   <= 1'b1;
      max_val <= '0;
      max_idx <= '0;
    end else if (valid) begin
      first <= 1'b0;
      // Strict greater-than keeps the lower index on a tie.
      if (first || (value > max_val)) begin
        max_val <= value;
        max_idx <= index;
      end
    end
  end

`ifdef CORR_SCAN_MARGIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_val <= '0;
    end else if (clear) begin
      second_val <= '0;
    end else if (valid) begin
      if (first) begin
        second_val <= '0;
      end else if (value > max_val) begin
        second_val <= max_val;
      end else if (value > second_val) begin
        second_val <= value;
      end
    end
  end
`endif

endmodule

// File: rtl/corr_scanner.sv
// Scans the correlator dispatcher: restart integration, wait, read 8x16-bit
// results over the byte bus, report the peak. CORR_SCAN_MARGIN_EN adds margin.
module corr_scanner
  import corr_pkg::*;
#(
  parameter int INTEG_CYCLES = 2080,
  parameter int RD_WAIT      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [7:0]            bus_addr,
  output logic                  bus_cs,
  output logic                  bus_oe,
  output logic                  bus_we,
  input  logic [7:0]            bus_din,
  output logic                  busy,
  output logic                  done,
  output logic [CORR_RES_W-1:0] peak_val,
  output logic [2:0]            peak_idx
`ifdef CORR_SCAN_MARGIN_EN
  ,
  output logic [CORR_RES_W-1:0] margin
`endif
);

  localparam logic [15:0] INTEG_LOAD = 16'(INTEG_CYCLES - 1);
  localparam logic [3:0]  WAIT_LOAD  = 4'(RD_WAIT - 1);

  corr_state_t state, state_next;

  logic [15:0]           integ_cnt;
  logic [3:0]            wait_cnt;
  logic [3:0]            byte_ptr;
  logic [7:0]            low_byte;
  logic                  trk_clear;
  logic                  trk_valid;
  logic [CORR_RES_W-1:0] trk_max;
  logic [2:0]            trk_idx;
`ifdef CORR_SCAN_MARGIN_EN
  logic [CORR_RES_W-1:0] trk_second;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      integ_cnt <= '0;
      wait_cnt  <= '0;
      byte_ptr  <= '0;
      low_byte  <= '0;
      peak_val  <= '0;
      peak_idx  <= '0;
`ifdef CORR_SCAN_MARGIN_EN
      margin    <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        ST_RESTART: begin
          integ_cnt <= INTEG_LOAD;
          byte_ptr  <= '0;
        end
        ST_INTEG: if (integ_cnt != '0) integ_cnt <= integ_cnt - 16'd1;
        ST_ADDR:  wait_cnt <= WAIT_LOAD;
        ST_WAIT:  wait_cnt <= wait_cnt - 4'd1;
        ST_LATCH: begin
          if (!byte_ptr[0]) low_byte <= bus_din;
          byte_ptr <= byte_ptr + 4'd1;
        end
        ST_DONE: begin
          peak_val <= trk_max;
          peak_idx <= trk_idx;
`ifdef CORR_SCAN_MARGIN_EN
          margin   <= trk_max - trk_second;
`endif
        end
        default: ;
      endcase
    end
  end

  // WAIT holds RD_WAIT-1 cycles so ADDR+WAIT+LATCH spans 1+RD_WAIT cycles.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_RESTART;
      ST_RESTART: state_next = ST_INTEG;
      ST_INTEG:   if (integ_cnt == '0) state_next = ST_ADDR;
      ST_ADDR:    state_next = (RD_WAIT == 1) ? ST_LATCH : ST_WAIT;
      ST_WAIT:    if (wait_cnt <= 4'd1) state_next = ST_LATCH;
      ST_LATCH:   state_next = (byte_ptr == 4'd15) ? ST_DONE : ST_ADDR;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_addr = 8'h00;
    bus_cs   = 1'b0;
    bus_oe   = 1'b0;
    bus_we   = 1'b0;
    case (state)
      ST_RESTART: bus_addr = CORR_RESTART_ADDR;
      ST_ADDR, ST_WAIT, ST_LATCH: begin
        bus_addr = {4'h0, byte_ptr};
        bus_cs   = 1'b1;
        bus_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign trk_clear = (state == ST_RESTART);
  assign trk_valid = (state == ST_LATCH) && byte_ptr[0];

  corr_max_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (trk_clear),
    .valid      (trk_valid),
    .value      ({bus_din, low_byte}),
    .index      (byte_ptr[3:1]),
    .max_val    (trk_max),
    .max_idx    (trk_idx)
`ifdef CORR_SCAN_MARGIN_EN
    ,
    .second_val (trk_second)
`endif
  );

endmodule

// File: tb/tb_corr_scanner.sv
// Directed bench for corr_scanner: DUT a (RD_WAIT=1) and DUT b (RD_WAIT=3),
// each fed by a dispatcher model whose read data lags the address by RD_WAIT.
module tb_corr_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  bus_addr_a, bus_addr_b;
  logic        bus_cs_a, bus_cs_b, bus_oe_a, bus_oe_b, bus_we_a, bus_we_b;
  logic [7:0]  bus_din_a, bus_din_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] peak_val_a, peak_val_b;
  logic [2:0]  peak_idx_a, peak_idx_b;
`ifdef CORR_SCAN_MARGIN_EN
  logic [15:0] margin_a, margin_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ch_val [8];
  logic [7:0]  addr_d_a;
  logic [7:0]  addr_d_b [3];

  always #5 clk = ~clk;

  corr_scanner #(.INTEG_CYCLES(2080), .RD_WAIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .bus_addr(bus_addr_a), .bus_cs(bus_cs_a), .bus_oe(bus_oe_a), .bus_we(bus_we_a),
    .bus_din(bus_din_a), .busy(busy_a), .done(done_a),
    .peak_val(peak_val_a), .peak_idx(peak_idx_a)
`ifdef CORR_SCAN_MARGIN_EN
    , .margin(margin_a)
`endif
  );

  corr_scanner #(.INTEG_CYCLES(2080), .RD_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .bus_addr(bus_addr_b), .bus_cs(bus_cs_b), .bus_oe(bus_oe_b), .bus_we(bus_we_b),
    .bus_din(bus_din_b), .busy(busy_b), .done(done_b),
    .peak_val(peak_val_b), .peak_idx(peak_idx_b)
`ifdef CORR_SCAN_MARGIN_EN
    , .margin(margin_b)
`endif
  );

  // Dispatcher model: data is valid RD_WAIT cycles after the address appears.
  always @(posedge clk) begin
    addr_d_a    <= bus_addr_a;
    addr_d_b[0] <= bus_addr_b;
    addr_d_b[1] <= addr_d_b[0];
    addr_d_b[2] <= addr_d_b[1];
  end

  always_comb begin
    bus_din_a = addr_d_a[0]    ? ch_val[addr_d_a[3:1]][15:8]    : ch_val[addr_d_a[3:1]][7:0];
    bus_din_b = addr_d_b[2][0] ? ch_val[addr_d_b[2][3:1]][15:8] : ch_val[addr_d_b[2][3:1]][7:0];
  end

  task automatic load_ramp();
    for (int c = 0; c < 8; c++) ch_val[c] = 16'(16'h0100 * c + 5);
  endtask

  // One scan; cycle 0 is the cycle start is high. extra_at re-pulses start.
  task automatic run_scan(input bit use_b, input int extra_at, output int done_cyc,
                          output int ff_cnt, output int done_cnt,
                          output logic busy1, output logic busy_end);
    logic d, b;
    logic [7:0] a;
    done_cyc = -1; ff_cnt = 0; done_cnt = 0; busy1 = 1'b0; busy_end = 1'b1;
    @(posedge clk); #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n < 3000; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      if (n == extra_at) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      a = use_b ? bus_addr_b : bus_addr_a;
      d = use_b ? done_b : done_a;
      b = use_b ? busy_b : busy_a;
      if (a == 8'hFF) ff_cnt++;
      if (n == 1) busy1 = b;
      if (d) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc >= 0 && n == done_cyc + 1) busy_end = b;
      if (done_cyc >= 0 && n >= done_cyc + 4) break;
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    load_ramp();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus_addr_a, bus_cs_a, bus_oe_a, bus_we_a, busy_a, done_a} !== 13'h0) begin
      n_err++; $display("FAIL reset_bus_a: got %h expected 0", {bus_addr_a, bus_cs_a, bus_oe_a, bus_we_a, busy_a, done_a});
    end
    n_vec++;
    if ({peak_val_a, peak_idx_a, peak_val_b, peak_idx_b} !== 38'h0) begin
      n_err++; $display("FAIL reset_results: got %h %h %h %h expected 0", peak_val_a, peak_idx_a, peak_val_b, peak_idx_b);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus_addr_a, bus_cs_a, busy_a, done_a, busy_b, bus_addr_b} !== 20'h0) begin
      n_err++; $display("FAIL idle_after_reset: got %h expected 0", {bus_addr_a, bus_cs_a, busy_a, done_a, busy_b, bus_addr_b});
    end
  endtask

  task automatic test_ramp();
    int dc, ff, dn;
    logic b1, be;
    load_ramp();
    run_scan(1'b0, -1, dc, ff, dn, b1, be);
    n_vec++;
    if (dc !== 2114) begin n_err++; $display("FAIL ramp_done_cycle: got %0d expected 2114", dc); end
    n_vec++;
    if (peak_val_a !== 16'h0705) begin n_err++; $display("FAIL ramp_peak_val: got %h expected 0705", peak_val_a); end
    n_vec++;
    if (peak_idx_a !== 3'd7) begin n_err++; $display("FAIL ramp_peak_idx: got %0d expected 7", peak_idx_a); end
    n_vec++;
    if (b1 !== 1'b1 || be !== 1'b0) begin n_err++; $display("FAIL ramp_busy: got %b/%b expected 1/0", b1, be); end
    n_vec++;
    if (ff !== 1 || dn !== 1) begin n_err++; $display("FAIL ramp_restart_done: got ff=%0d done=%0d expected 1/1", ff, dn); end
`ifdef CORR_SCAN_MARGIN_EN
    n_vec++;
    if (margin_a !== 16'h0100) begin n_err++; $display("FAIL ramp_margin: got %h expected 0100", margin_a); end
`endif
  endtask

  task automatic test_tie();
    int dc, ff, dn;
    logic b1, be;
    for (int c = 0; c < 8; c++) ch_val[c] = 16'h1234;
    run_scan(1'b0, -1, dc, ff, dn, b1, be);
    n_vec++;
    if (peak_val_a !== 16'h1234 || peak_idx_a !== 3'd0) begin
      n_err++; $display("FAIL tie: got val=%h idx=%0d expected 1234/0", peak_val_a, peak_idx_a);
    end
`ifdef CORR_SCAN_MARGIN_EN
    n_vec++;
    if (margin_a !== 16'h0000) begin n_err++; $display("FAIL tie_margin: got %h expected 0000", margin_a); end
`endif
  endtask

  task automatic test_byte_order();
    int dc, ff, dn;
    logic b1, be;
    for (int c = 0; c < 8; c++) ch_val[c] = 16'h00FF;
    ch_val[3] = 16'hFFFF;
    run_scan(1'b0, -1, dc, ff, dn, b1, be);
    n_vec++;
    if (peak_val_a !== 16'hFFFF || peak_idx_a !== 3'd3) begin
      n_err++; $display("FAIL byte_order: got val=%h idx=%0d expected FFFF/3", peak_val_a, peak_idx_a);
    end
`ifdef CORR_SCAN_MARGIN_EN
    n_vec++;
    if (margin_a !== 16'hFF00) begin n_err++; $display("FAIL byte_order_margin: got %h expected FF00", margin_a); end
`endif
  endtask

  task automatic test_second_start();
    int dc, ff, dn;
    logic b1, be;
    load_ramp();
    run_scan(1'b0, 100, dc, ff, dn, b1, be);
    n_vec++;
    if (dn !== 1) begin n_err++; $display("FAIL second_start_done_count: got %0d expected 1", dn); end
    n_vec++;
    if (ff !== 1) begin n_err++; $display("FAIL second_start_restart_count: got %0d expected 1", ff); end
    n_vec++;
    if (dc !== 2114 || peak_val_a !== 16'h0705) begin
      n_err++; $display("FAIL second_start_result: got cyc=%0d val=%h expected 2114/0705", dc, peak_val_a);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit found = 1'b0;
    int dc, ff, dn;
    logic b1, be;
    load_ramp();
    @(posedge clk); #1; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (bus_addr_a == 8'h06 && bus_cs_a) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL mid_reset_reach_read: got none expected addr 06"); end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus_addr_a, bus_cs_a, bus_oe_a, bus_we_a, busy_a, done_a} !== 13'h0) begin
      n_err++; $display("FAIL mid_reset_bus: got %h expected 0", {bus_addr_a, bus_cs_a, bus_oe_a, bus_we_a, busy_a, done_a});
    end
    n_vec++;
    if (peak_val_a !== 16'h0 || peak_idx_a !== 3'd0) begin
      n_err++; $display("FAIL mid_reset_results: got %h/%0d expected 0/0", peak_val_a, peak_idx_a);
    end
`ifdef CORR_SCAN_MARGIN_EN
    n_vec++;
    if (margin_a !== 16'h0) begin n_err++; $display("FAIL mid_reset_margin: got %h expected 0", margin_a); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) ch_val[c] = 16'(16'h0800 - 16'h0100 * c);
    run_scan(1'b0, -1, dc, ff, dn, b1, be);
    n_vec++;
    if (dc !== 2114 || peak_val_a !== 16'h0800 || peak_idx_a !== 3'd0 || ff !== 1) begin
      n_err++; $display("FAIL mid_reset_rescan: got cyc=%0d val=%h idx=%0d ff=%0d expected 2114/0800/0/1", dc, peak_val_a, peak_idx_a, ff);
    end
  endtask

  task automatic test_rd_wait3();
    int dc, ff, dn;
    logic b1, be;
    load_ramp();
    run_scan(1'b1, -1, dc, ff, dn, b1, be);
    n_vec++;
    if (dc !== 2146) begin n_err++; $display("FAIL rdwait3_done_cycle: got %0d expected 2146", dc); end
    n_vec++;
    if (peak_val_b !== 16'h0705 || peak_idx_b !== 3'd7) begin
      n_err++; $display("FAIL rdwait3_result: got val=%h idx=%0d expected 0705/7", peak_val_b, peak_idx_b);
    end
`ifdef CORR_SCAN_MARGIN_EN
    n_vec++;
    if (margin_b !== 16'h0100) begin n_err++; $display("FAIL rdwait3_margin: got %h expected 0100", margin_b); end
`endif
    n_vec++;
    if (bus_we_b !== 1'b0 || busy_b !== 1'b0) begin
      n_err++; $display("FAIL rdwait3_idle: got we=%b busy=%b expected 0/0", bus_we_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_tie();
    test_byte_order();
    test_second_start();
    test_reset_mid_scan();
    test_rd_wait3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
